// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer for the EX stage.
//
// Performs MULT/MULTU/DIV/DIVU with one iteration per clock and owns the
// HI/LO register pair. busy is high while an operation is in flight, so the
// hazard unit can stall dependent MFHI/MFLO. Start-to-done latency is
// DATA_W+3 cycles.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   start    in   launch request, accepted in IDLE or DONE
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   src1     in   multiplicand / dividend
//   src2     in   multiplier / divisor
//   flush    in   cancels an in-flight operation
//   hi_we    in   MTHI write enable (IDLE/DONE only)
//   lo_we    in   MTLO write enable (IDLE/DONE only)
//   wr_data  in   MTHI/MTLO data
//   busy     out  operation in flight (PREP, CALC, FIX)
//   done     out  one-cycle pulse; HI/LO hold the new result
//   dz       out  divide-by-zero flag, valid with done
//   hi, lo   out  HI/LO registers
//
// Optional build macro: MULDIV_DZ_SHORTCUT_EN. When defined, a divide by
// zero jumps PREP -> FIX and skips CALC (done three cycles after accept).

module muldiv_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              dz,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_a;        // operands captured at accept
    logic [DATA_W-1:0]   r_b;
    logic                r_sign1;
    logic                r_sign2;
    logic [DATA_W-1:0]   r_mag1;     // |src1|: multiplicand for MUL
    logic [DATA_W-1:0]   r_mag2;     // |src2|: divisor for DIV
    logic [2*DATA_W-1:0] r_acc;      // MUL partial product / DIV remainder in [DATA_W:0]
    logic [DATA_W-1:0]   r_q;        // MUL multiplier shifter / DIV dividend-quotient shifter
    logic [CNT_W-1:0]    r_cnt;
    logic                r_dz_op;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_accepting;
    logic                w_accept;
    logic                w_is_div;
    logic                w_is_signed;
    logic                w_b_zero;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W:0]     w_msum;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_trial;
    logic                w_borrow;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    assign w_accepting = (r_state == S_IDLE) || (r_state == S_DONE);
    // A flush in an accepting state drops a same-cycle start.
    assign w_accept    = w_accepting && start && !flush;
    assign w_is_div    = r_op[1];
    assign w_is_signed = ~r_op[0];
    assign w_b_zero    = (r_b == '0);
    assign w_abs_a     = (w_is_signed && r_a[DATA_W-1]) ? -r_a : r_a;
    assign w_abs_b     = (w_is_signed && r_b[DATA_W-1]) ? -r_b : r_b;

    // Shift-add step: add multiplicand when the current multiplier LSB is set.
    assign w_msum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                  + {1'b0, (r_q[0] ? r_mag1 : {DATA_W{1'b0}})};

    // Restoring-divide step: bring in the next dividend bit and trial-subtract.
    assign w_shift               = {r_acc[DATA_W-1:0], r_q[DATA_W-1]};
    assign {w_borrow, w_trial}   = {1'b0, w_shift} - {2'b00, r_mag2};

    assign w_prod = (w_is_signed && (r_sign1 ^ r_sign2)) ? -r_acc : r_acc;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        w_res_hi = w_prod[2*DATA_W-1:DATA_W];
        w_res_lo = w_prod[DATA_W-1:0];
        if (w_is_div) begin
            if (r_dz_op) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = (w_is_signed && r_sign1) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
                w_res_lo = (w_is_signed && (r_sign1 ^ r_sign2)) ? -r_q : r_q;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_PREP;
            S_PREP: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
`ifdef MULDIV_DZ_SHORTCUT_EN
                    w_next = (w_is_div && w_b_zero) ? S_FIX : S_CALC;
`else
                    w_next = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (flush)                      w_next = S_IDLE;
                else if (r_cnt == CNT_W'(1))    w_next = S_FIX;
            end
            S_FIX:  w_next = flush ? S_IDLE : S_DONE;
            S_DONE: w_next = w_accept ? S_PREP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_mag1  <= '0;
            r_mag2  <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dz_op <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_accept) begin
                r_op <= op;
                r_a  <= src1;
                r_b  <= src2;
            end

            case (r_state)
                S_PREP: begin
                    r_sign1 <= w_is_signed & r_a[DATA_W-1];
                    r_sign2 <= w_is_signed & r_b[DATA_W-1];
                    r_mag1  <= w_abs_a;
                    r_mag2  <= w_abs_b;
                    r_acc   <= '0;
                    r_q     <= w_is_div ? w_abs_a : w_abs_b;
                    r_cnt   <= CNT_W'(DATA_W);
                    r_dz_op <= w_is_div & w_b_zero;
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_is_div) begin
                        r_acc[DATA_W:0] <= w_borrow ? w_shift : w_trial;
                        r_q             <= {r_q[DATA_W-2:0], ~w_borrow};
                    end else begin
                        r_acc <= {w_msum, r_acc[DATA_W-1:1]};
                        r_q   <= r_q >> 1;
                    end
                end
                default: ;
            endcase

            // HI/LO: result load at the end of FIX unless flushed; MTHI/MTLO
            // only while not busy.
            if (r_state == S_FIX) begin
                if (!flush) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else if (w_accepting) begin
                if (hi_we) r_hi <= wr_data;
                if (lo_we) r_lo <= wr_data;
            end
        end
    end

    assign busy = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign dz   = (r_state == S_DONE) && r_dz_op;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Directed vectors plus
// randomized operations compared against a plain-arithmetic reference model.

module tb_muldiv_seq;

`ifdef MULDIV_DZ_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src1    (src1),
        .src2    (src2),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .dz      (dz),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output bit ez);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 0) begin ez = 1'b1; eh = a; el = '1; end
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin ez = 1'b1; eh = a; el = '1; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endfunction

    // Called at a negedge: drives start in cycle 0, follows the op to its done
    // cycle and returns at the negedge of that done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit mthi);
        logic [31:0] eh, el, gh, gl;
        bit          ez;
        logic        gz, gbusy;
        int          lat, done_cyc, busy_bad, dz_bad;
        model(o, a, b, eh, el, ez);
        lat = (ez && SHORTCUT) ? 3 : 35;
        start = 1'b1; op = o; src1 = a; src2 = b;
        if (mthi) begin hi_we = 1'b1; wr_data = 32'hDEAD0001; end
        done_cyc = -1; busy_bad = 0; dz_bad = 0;
        gh = '0; gl = '0; gz = 1'b0; gbusy = 1'b0;
        for (int c = 1; c <= lat + 3 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1 && mthi) check("mthi_with_start", hi, 32'hDEAD0001);
            hi_we = 1'b0;
            start = hold && (c < lat - 1);
            src1  = $urandom;
            src2  = $urandom;
            if (done === 1'b1) begin
                done_cyc = c; gh = hi; gl = lo; gz = dz; gbusy = busy;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (dz !== 1'b0) dz_bad++;
            end
        end
        check($sformatf("latency op%0d %h,%h", o, a, b), done_cyc, lat);
        check($sformatf("hi op%0d %h,%h", o, a, b), gh, eh);
        check($sformatf("lo op%0d %h,%h", o, a, b), gl, el);
        check($sformatf("dz op%0d %h,%h", o, a, b), gz, ez);
        check("busy_low_in_done", gbusy, 0);
        check("busy_high_in_flight", busy_bad, 0);
        check("dz_low_outside_done", dz_bad, 0);
    endtask

    task automatic go_idle();
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_dz_low", dz, 0);
    endtask

    initial begin
        int          n_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          b2b;

        rst = 1'b1; start = 1'b0; op = '0; src1 = '0; src2 = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, each also compared with its known constant result.
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0); go_idle();
        check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0); go_idle();
        check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0); go_idle();
        check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0); go_idle();   // start held through CALC
        check("divu_const", {hi, lo}, 64'h00000002_0000000E);
        run_op(2'b11, 32'h1234, 32'd0, 1'b0, 1'b0); go_idle();
        check("divu_zero_const", {hi, lo}, 64'h00001234_FFFFFFFF);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        // Back-to-back from the DONE cycle, with MTHI in the accept cycle.
        run_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b1); go_idle();
        check("b2b_const", {hi, lo}, 64'h00000000_00000006);

        // MTHI/MTLO while idle.
        hi_we = 1'b1; wr_data = 32'h11111111;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h22222222;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi_idle", hi, 32'h11111111);
        check("mtlo_idle", lo, 32'h22222222);

        // Flush in cycle 10, MTHI attempted in cycle 3 while busy.
        start = 1'b1; op = 2'b01; src1 = 32'd5; src2 = 32'd6;
        n_done = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = 1'b0;
            hi_we = (c == 3);
            wr_data = 32'hAA;
            flush = (c == 10);
            if (done === 1'b1) n_done++;
            if (c == 2)  check("flush_busy_before", busy, 1);
            if (c == 11) check("flush_busy_after", busy, 0);
        end
        check("flush_no_done", n_done, 0);
        check("flush_hi_kept", hi, 32'h11111111);
        check("flush_lo_kept", lo, 32'h22222222);

        // Randomized operations, sometimes back-to-back or with start held.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 5000));
            b2b = ($urandom_range(0, 1) == 1);
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), 1'b0);
            if (!b2b) go_idle();
        end
        if (done === 1'b1) go_idle();

        // Reset in the middle of an operation.
        start = 1'b1; op = 2'b00; src1 = 32'h1234; src2 = 32'h5678;
        repeat (5) begin @(negedge clk); start = 1'b0; end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) n_done++; end
        check("midrst_no_done", n_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
